// File: rtl/vector_exec_unit.sv
// Multi-beat vector ALU: REG_WIDTH operands processed as ELEM_WIDTH elements, LANES elements per clock.
// Latency: request accepted at edge k -> out_valid after edge k+BEATS; one op per BEATS+2 cycles at best.
// Backpressure: in_ready only in IDLE; result/zero/out_valid held in DONE until out_ready.
// Build option: define VEC_SAT_EN for signed-saturating ADD/SUB (wrapping otherwise).
module vector_exec_unit #(
    parameter int REG_WIDTH  = 256,
    parameter int ELEM_WIDTH = 32,
    parameter int LANES      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] b,
    input  logic [31:0]          imm,
    input  logic                 use_imm,
    input  logic [2:0]           alu_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] result,
    output logic                 zero,
    output logic                 busy
);

    localparam int E      = ELEM_WIDTH;
    localparam int BEAT_W = ELEM_WIDTH * LANES;
    localparam int BEATS  = REG_WIDTH / BEAT_W;
    localparam int ELEMS  = REG_WIDTH / ELEM_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SH_W   = $clog2(ELEM_WIDTH);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef VEC_SAT_EN
    localparam logic [E-1:0] SMAX = {1'b0, {(E-1){1'b1}}};
    localparam logic [E-1:0] SMIN = {1'b1, {(E-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [REG_WIDTH-1:0] a_q;
    logic [REG_WIDTH-1:0] b_q;
    logic [2:0]           op_q;
    logic [E-1:0]         imm_ext;
    logic [REG_WIDTH-1:0] b_src;
    logic [REG_WIDTH-1:0] result_nxt;
    logic                 last_beat;

    // One element of the datapath; low E bits of the product are identical for signed and unsigned
    function automatic logic [E-1:0] elem_alu(input logic [2:0] op,
                                              input logic [E-1:0] x,
                                              input logic [E-1:0] y);
        logic [E-1:0] r;
        logic [E-1:0] sum;
        logic [E-1:0] dif;
        sum = x + y;
        dif = x - y;
        r   = '0;
        case (op)
            OP_ADD: begin
                r = sum;
`ifdef VEC_SAT_EN
                // Overflow only when both operands share a sign the sum lacks
                if ((x[E-1] == y[E-1]) && (sum[E-1] != x[E-1]))
                    r = x[E-1] ? SMIN : SMAX;
`endif
            end
            OP_SUB: begin
                r = dif;
`ifdef VEC_SAT_EN
                // Overflow only when operand signs differ and the difference flips away from x
                if ((x[E-1] != y[E-1]) && (dif[E-1] != x[E-1]))
                    r = x[E-1] ? SMIN : SMAX;
`endif
            end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = {{(E-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLL:  r = x << y[SH_W-1:0];
            OP_MUL:  r = x * y;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Immediate sign-extended or truncated to one element
    assign imm_ext = E'(signed'(imm));

    // B source: immediate broadcast to every element or the b vector
    always_comb begin
        b_src = '0;
        for (int i = 0; i < ELEMS; i++) begin
            b_src[i*E +: E] = use_imm ? imm_ext : b[i*E +: E];
        end
    end

    // Current beat's lanes merged into the held result; other slices untouched
    always_comb begin
        result_nxt = result;
        for (int l = 0; l < LANES; l++) begin
            result_nxt[int'(cnt)*BEAT_W + l*E +: E] =
                elem_alu(op_q, a_q[int'(cnt)*BEAT_W + l*E +: E], b_q[int'(cnt)*BEAT_W + l*E +: E]);
        end
    end

    assign last_beat = (cnt == LAST_BEAT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (last_beat) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, beat counter, result accumulation and zero flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q  <= a;
                        b_q  <= b_src;
                        op_q <= alu_ctrl;
                        cnt  <= '0;
                    end
                end
                S_EXEC: begin
                    result <= result_nxt;
                    if (last_beat) begin
                        cnt  <= '0;
                        zero <= (result_nxt == '0);
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
